strobe_fifo: RTL and testbench
==============================

STROBE_FIFO -- requirements
Module: strobe_fifo

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits; SHALL be >= 1.
REQ-002 Parameter DEPTH, default 4, number of storage entries; SHALL be a power of two and >= 2.
REQ-003 clk  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 strobe_in  input  1  one-cycle write pulse from a strobe-crossing stage; no backpressure.
REQ-006 data_in  input  WIDTH  word that SHALL be captured when strobe_in is high.
REQ-007 data_out  output  WIDTH  head-of-queue word; valid only while valid_out is high.
REQ-008 valid_out  output  1  queue not empty.
REQ-009 ready_in  input  1  consumer accepts the head word; a pop SHALL occur when valid_out and ready_in are both high.
REQ-010 count  output  $clog2(DEPTH+1)  number of words currently stored.
REQ-011 overflow  output  1  sticky flag for a strobe that arrived while the queue was full.
REQ-012 clear_overflow  input  1  clears overflow.

Function
REQ-013 Push SHALL occur when strobe_in is high and the queue is either not full or popping in the same cycle.
REQ-014 Full with simultaneous strobe_in and pop: SHALL push and pop together; count stays DEPTH, and the new word is enqueued at the tail.
REQ-015 Full with strobe_in and no pop: data_in SHALL be dropped, no stored word altered, overflow set on next edge.
REQ-016 Empty with strobe_in: valid_out SHALL rise and data_out equal data_in one cycle after the strobe edge (latency 1).
REQ-017 data_out SHALL be first-word-fall-through: the head word is presented without a read request.
REQ-018 ready_in while empty SHALL have no effect; count SHALL never underflow.
REQ-019 count SHALL increment on push-only, decrement on pop-only, and hold on push+pop or on idle.
REQ-020 Read and write pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0 without gaps.
REQ-021 Word order out SHALL equal accepted-strobe order in.
REQ-022 overflow: set beats clear when both occur in the same cycle; otherwise clear_overflow SHALL drop it on the next edge.
REQ-023 Strobes on consecutive cycles SHALL each be handled independently, so back-to-back pushes are accepted.

Reset
REQ-024 While reset is high at an edge: pointers=0, count=0, valid_out=0, overflow=0; strobe_in and ready_in SHALL be ignored.
REQ-025 Reset asserted mid-stream SHALL discard all stored words; data_out after reset is don't-care while valid_out=0.
REQ-026 Storage array contents SHALL NOT require reset.

Structure
REQ-027 No shared package; pointer and count widths SHALL be derived locally from DEPTH.
REQ-028 Storage SHALL be a sub-module strobe_fifo_mem (one write port, one asynchronous read port) so it can map to distributed RAM.
REQ-029 All control (pointers, count, overflow) SHALL live in strobe_fifo; no combinational path from strobe_in to valid_out.

Verification
REQ-030 Reset, then strobe 0xA5 at cycle 1, ready_in=0 -> cycle 2: valid_out=1, data_out=0xA5, count=1.
REQ-031 DEPTH=4, strobes 0x01..0x04 back-to-back, then ready_in=1 -> outputs 0x01,0x02,0x03,0x04 on successive cycles; count 4->0; valid_out=0 after the last pop.
REQ-032 Fill with 0x10..0x13, strobe 0x99 with ready_in=0 -> overflow=1, count=4, subsequent pops yield 0x10..0x13 only.
REQ-033 Full, strobe 0x55 with ready_in=1 in the same cycle -> pops 0x10, count stays 4, 0x55 emerges fourth.
REQ-034 overflow=1, clear_overflow and a full-drop strobe in the same cycle -> overflow stays 1; clear alone next cycle -> 0.
REQ-035 Three words queued, reset for one cycle -> valid_out=0, count=0, overflow=0; a following strobe 0x3C appears alone.

Source files
------------

// File: rtl/strobe_fifo_mem.sv
// Storage array for strobe_fifo: one synchronous write port, one asynchronous read port.
// No reset on the array so it can map onto distributed RAM.
module strobe_fifo_mem #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [WIDTH-1:0]         rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/strobe_fifo.sv
// First-word-fall-through FIFO fed by one-cycle write strobes with no backpressure.
// Strobes arriving while full and not popping are dropped and flagged in a sticky overflow bit.
module strobe_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       strobe_in,
   input  logic [WIDTH-1:0]           data_in,
   output logic [WIDTH-1:0]           data_out,
   output logic                       valid_out,
   input  logic                       ready_in,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overflow,
   input  logic                       clear_overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          valid_q, valid_d;
   logic          ovf_q, ovf_d;
   logic          full, pop, push;

   assign full = (count_q == CW'(DEPTH));
   assign pop  = valid_q && ready_in;
   // A full queue can still accept a strobe when the head leaves in the same cycle.
   assign push = strobe_in && (!full || pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CW'(1);
      end
      if (strobe_in && !push) begin
         ovf_d = 1'b1;
      end else if (clear_overflow) begin
         ovf_d = 1'b0;
      end
      valid_d = (count_d != '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         valid_q  <= valid_d;
         ovf_q    <= ovf_d;
      end
   end

   strobe_fifo_mem #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
   ) u_mem (
      .clk     (clk),
      .we_i    (push && !reset),
      .waddr_i (wr_ptr_q),
      .wdata_i (data_in),
      .raddr_i (rd_ptr_q),
      .rdata_o (data_out)
   );

   assign valid_out = valid_q;
   assign count     = count_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_strobe_fifo.sv
// Self-checking bench for strobe_fifo: directed vector table, then random traffic against a queue model.
module tb_strobe_fifo;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH + 1);

   logic             clk;
   logic             reset;
   logic             strobe_in;
   logic [WIDTH-1:0] data_in;
   logic [WIDTH-1:0] data_out;
   logic             valid_out;
   logic             ready_in;
   logic [CW-1:0]    count;
   logic             overflow;
   logic             clear_overflow;

   strobe_fifo #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .strobe_in      (strobe_in),
      .data_in        (data_in),
      .data_out       (data_out),
      .valid_out      (valid_out),
      .ready_in       (ready_in),
      .count          (count),
      .overflow       (overflow),
      .clear_overflow (clear_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic             rst;
      logic             stb;
      logic [WIDTH-1:0] din;
      logic             rdy;
      logic             clr;
      logic             ev;
      logic [WIDTH-1:0] ed;
      logic [CW-1:0]    ec;
      logic             eo;
   } vec_t;

   vec_t tbl[$];
   int   n_vec;
   int   n_bad;

   logic [WIDTH-1:0] mq[$];
   logic             movf;

   task automatic add(input logic rst, input logic stb, input logic [WIDTH-1:0] din,
                      input logic rdy, input logic clr, input logic ev,
                      input logic [WIDTH-1:0] ed, input logic [CW-1:0] ec, input logic eo);
      vec_t v;
      v.rst = rst; v.stb = stb; v.din = din; v.rdy = rdy; v.clr = clr;
      v.ev = ev; v.ed = ed; v.ec = ec; v.eo = eo;
      tbl.push_back(v);
   endtask

   task automatic drive_and_check(input string name, input int idx, input vec_t v);
      reset          = v.rst;
      strobe_in      = v.stb;
      data_in        = v.din;
      ready_in       = v.rdy;
      clear_overflow = v.clr;
      @(posedge clk);
      #1;
      n_vec++;
      if (valid_out !== v.ev || count !== v.ec || overflow !== v.eo ||
          (v.ev && data_out !== v.ed)) begin
         n_bad++;
         $display("FAIL %s[%0d]: got valid=%b data=%h count=%0d ovf=%b, want valid=%b data=%h count=%0d ovf=%b",
                  name, idx, valid_out, data_out, count, overflow, v.ev, v.ed, v.ec, v.eo);
      end
   endtask

   initial begin
      n_vec = 0;
      n_bad = 0;
      reset = 1'b1; strobe_in = 1'b0; data_in = '0; ready_in = 1'b0; clear_overflow = 1'b0;

      //   rst stb din    rdy clr   ev  ed     ec eo
      add(1, 0, 8'h00, 0, 0,   0, 8'h00, 0, 0);
      add(0, 1, 8'hA5, 0, 0,   1, 8'hA5, 1, 0);
      add(0, 0, 8'h00, 1, 0,   0, 8'h00, 0, 0);
      add(0, 1, 8'h01, 0, 0,   1, 8'h01, 1, 0);
      add(0, 1, 8'h02, 0, 0,   1, 8'h01, 2, 0);
      add(0, 1, 8'h03, 0, 0,   1, 8'h01, 3, 0);
      add(0, 1, 8'h04, 0, 0,   1, 8'h01, 4, 0);
      add(0, 0, 8'h00, 1, 0,   1, 8'h02, 3, 0);
      add(0, 0, 8'h00, 1, 0,   1, 8'h03, 2, 0);
      add(0, 0, 8'h00, 1, 0,   1, 8'h04, 1, 0);
      add(0, 0, 8'h00, 1, 0,   0, 8'h00, 0, 0);
      add(0, 0, 8'h00, 1, 0,   0, 8'h00, 0, 0);
      add(0, 1, 8'h10, 0, 0,   1, 8'h10, 1, 0);
      add(0, 1, 8'h11, 0, 0,   1, 8'h10, 2, 0);
      add(0, 1, 8'h12, 0, 0,   1, 8'h10, 3, 0);
      add(0, 1, 8'h13, 0, 0,   1, 8'h10, 4, 0);
      add(0, 1, 8'h99, 0, 0,   1, 8'h10, 4, 1);
      add(0, 1, 8'h55, 1, 0,   1, 8'h11, 4, 1);
      add(0, 1, 8'h66, 0, 1,   1, 8'h11, 4, 1);
      add(0, 0, 8'h00, 0, 1,   1, 8'h11, 4, 0);
      add(0, 0, 8'h00, 1, 0,   1, 8'h12, 3, 0);
      add(0, 0, 8'h00, 1, 0,   1, 8'h13, 2, 0);
      add(0, 0, 8'h00, 1, 0,   1, 8'h55, 1, 0);
      add(0, 0, 8'h00, 1, 0,   0, 8'h00, 0, 0);
      add(0, 1, 8'h21, 0, 0,   1, 8'h21, 1, 0);
      add(0, 1, 8'h22, 0, 0,   1, 8'h21, 2, 0);
      add(0, 1, 8'h23, 0, 0,   1, 8'h21, 3, 0);
      add(1, 1, 8'h77, 1, 0,   0, 8'h00, 0, 0);
      add(0, 1, 8'h3C, 0, 0,   1, 8'h3C, 1, 0);
      add(0, 0, 8'h00, 1, 0,   0, 8'h00, 0, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         drive_and_check("table", i, tbl[i]);
      end

      // Hand sequence: overflow raised, then cleared by reset rather than clear_overflow.
      begin
         vec_t v;
         for (int i = 0; i < DEPTH + 1; i++) begin
            v = '{0, 1, WIDTH'(8'hC0 + i), 0, 0, 1, 8'hC0,
                  CW'((i < DEPTH) ? i + 1 : DEPTH), (i == DEPTH)};
            drive_and_check("ovf_fill", i, v);
         end
         v = '{1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0};
         drive_and_check("ovf_reset", 0, v);
      end

      // Random traffic against a queue model of the accepted-strobe order.
      mq.delete();
      movf = 1'b0;
      for (int i = 0; i < 600; i++) begin
         vec_t v;
         bit   do_pop, was_full;
         v.rst = ($urandom_range(99) < 2);
         v.stb = ($urandom_range(99) < 60);
         v.din = WIDTH'($urandom);
         v.rdy = ($urandom_range(99) < 40);
         v.clr = ($urandom_range(99) < 10);
         if (v.rst) begin
            mq.delete();
            movf = 1'b0;
         end else begin
            do_pop   = (mq.size() != 0) && v.rdy;
            was_full = (mq.size() == DEPTH);
            if (v.stb && was_full && !do_pop) movf = 1'b1;
            else if (v.clr) movf = 1'b0;
            if (do_pop) void'(mq.pop_front());
            if (v.stb && (!was_full || do_pop)) mq.push_back(v.din);
         end
         v.ev = (mq.size() != 0);
         v.ed = v.ev ? mq[0] : '0;
         v.ec = CW'(mq.size());
         v.eo = movf;
         drive_and_check("random", i, v);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
